pc_gen: RTL and testbench

//  Fetch-stage next-PC generator, directly upstream of PC_instr. Holds the architectural fetch PC register.

---
 rtl/pc_gen_pkg.sv | 28 ++
 rtl/pc_gen_bht.sv | 34 +++
 rtl/pc_gen.sv | 65 ++++++
 tb/tb_pc_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared widths and 2-bit branch counter encoding for the fetch next-PC generator.
package pc_gen_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PC_WIDTH = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Saturating step of one bimodal counter toward the resolved outcome.
  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    unique case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pc_gen_bht.sv
// Bimodal branch history table: combinational read, synchronous saturating write and reset.
module bht_2bit
  import pc_gen_pkg::*;
#(
  parameter int unsigned IDX_W = 6,
  parameter ctr_e        INIT  = WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  ctr_e table_q [DEPTH];

  // Same-index read during a write sees the pre-update counter.
  assign rd_taken = table_q[rd_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= INIT;
      end
    end else if (wr_en) begin
      table_q[wr_idx] <= ctr_next(table_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage next-PC generator: PC register, next-PC priority mux and BHT-based prediction.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned         BHT_IDX_W = 6,
  parameter ctr_e                BHT_INIT  = WNT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                F_stall_i,
  input  logic                mini_jmp_sel_i,
  input  logic [XLEN-1:0]     mini_jmp_i,
  input  logic                F_train_vaild_i,
  input  logic                E_redirect_i,
  input  logic [XLEN-1:0]     E_redirect_pc_i,
  input  logic                E_train_vaild_i,
  input  logic [PC_WIDTH-1:0] E_train_pc_i,
  input  logic                E_train_taken_i,
  output logic [PC_WIDTH-1:0] F_PC_o,
  output logic                F_predict_taken_o
);

  logic                bht_taken;
  logic [PC_WIDTH-1:0] pc_next;
  logic                unused_train_bits;

  assign unused_train_bits = ^{E_train_pc_i[PC_WIDTH-1:BHT_IDX_W+2], E_train_pc_i[1:0]};

  bht_2bit #(
    .IDX_W (BHT_IDX_W),
    .INIT  (BHT_INIT)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (F_PC_o[BHT_IDX_W+1:2]),
    .rd_taken (bht_taken),
    .wr_en    (E_train_vaild_i),
    .wr_idx   (E_train_pc_i[BHT_IDX_W+1:2]),
    .wr_taken (E_train_taken_i)
  );

  // jal is always taken; conditional branches follow the counter MSB.
  assign F_predict_taken_o = mini_jmp_sel_i & (~F_train_vaild_i | bht_taken);

  always_comb begin
    pc_next = F_PC_o + PC_WIDTH'(4);
    if (E_redirect_i) begin
      pc_next = E_redirect_pc_i[PC_WIDTH-1:0];
    end else if (F_stall_i) begin
      pc_next = F_PC_o;
    end else if (F_predict_taken_o) begin
      pc_next = mini_jmp_i[PC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      F_PC_o <= RESET_PC;
    end else begin
      F_PC_o <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios followed by random traffic against a counter-array model.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_stall_i;
  logic        mini_jmp_sel_i;
  logic [31:0] mini_jmp_i;
  logic        F_train_vaild_i;
  logic        E_redirect_i;
  logic [31:0] E_redirect_pc_i;
  logic        E_train_vaild_i;
  logic [31:0] E_train_pc_i;
  logic        E_train_taken_i;
  logic [31:0] F_PC_o;
  logic        F_predict_taken_o;

  always #5 clk = ~clk;

  pc_gen #(
    .RESET_PC  (RST_PC),
    .BHT_IDX_W (6)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .F_stall_i         (F_stall_i),
    .mini_jmp_sel_i    (mini_jmp_sel_i),
    .mini_jmp_i        (mini_jmp_i),
    .F_train_vaild_i   (F_train_vaild_i),
    .E_redirect_i      (E_redirect_i),
    .E_redirect_pc_i   (E_redirect_pc_i),
    .E_train_vaild_i   (E_train_vaild_i),
    .E_train_pc_i      (E_train_pc_i),
    .E_train_taken_i   (E_train_taken_i),
    .F_PC_o            (F_PC_o),
    .F_predict_taken_o (F_predict_taken_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  string       cur_tag  = "reset";

  // Reference state: fetch PC and one saturating counter (0..3) per table entry.
  logic [31:0] m_pc;
  int          m_bht[64];
  bit          m_valid = 1'b0;

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'h3f);
  endfunction

  task automatic step(input bit r, input bit st, input bit sel, input logic [31:0] jmp,
                      input bit fv, input bit red, input logic [31:0] rpc,
                      input bit tv, input logic [31:0] tpc, input bit tk);
    bit pred;
    rst = r; F_stall_i = st; mini_jmp_sel_i = sel; mini_jmp_i = jmp;
    F_train_vaild_i = fv; E_redirect_i = red; E_redirect_pc_i = rpc;
    E_train_vaild_i = tv; E_train_pc_i = tpc; E_train_taken_i = tk;
    pred = sel && (!fv || (m_bht[bidx(m_pc)] >= 2));
    if (m_valid) sb.push_back('{m_pc, pred, cur_tag});
    if (r) begin
      m_pc = RST_PC;
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      m_valid = 1'b1;
    end else begin
      if (tv) begin
        if (tk) m_bht[bidx(tpc)] = (m_bht[bidx(tpc)] == 3) ? 3 : m_bht[bidx(tpc)] + 1;
        else    m_bht[bidx(tpc)] = (m_bht[bidx(tpc)] == 0) ? 0 : m_bht[bidx(tpc)] - 1;
      end
      if (red)       m_pc = rpc;
      else if (st)   m_pc = m_pc;
      else if (pred) m_pc = jmp;
      else           m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic go(input logic [31:0] pc);
    step(0, 0, 0, 0, 0, 1, pc, 0, 0, 0);
  endtask

  task automatic train(input logic [31:0] pc, input bit tk);
    step(0, 1, 0, 0, 0, 0, 0, 1, pc, tk);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (F_PC_o !== e.pc) begin
        failures++;
        $display("FAIL %s.pc actual=%h required=%h", e.tag, F_PC_o, e.pc);
      end
      checks++;
      if (F_predict_taken_o !== e.pred) begin
        failures++;
        $display("FAIL %s.pred actual=%b required=%b (pc=%h)", e.tag, F_predict_taken_o, e.pred, e.pc);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    cur_tag = "reset";
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    cur_tag = "jal";
    go(32'h8000_0010);
    step(0, 0, 1, 32'h8000_0100, 0, 0, 0, 0, 0, 0);
    idle(1);

    cur_tag = "cold_branch";
    go(32'h8000_0020);
    step(0, 0, 1, 32'h8000_0300, 1, 0, 0, 0, 0, 0);
    train(32'h8000_0020, 1);
    train(32'h8000_0020, 1);
    go(32'h8000_0020);
    step(0, 0, 1, 32'h8000_0300, 1, 0, 0, 0, 0, 0);
    idle(1);

    cur_tag = "redirect_stall";
    step(0, 1, 0, 0, 0, 1, 32'h8000_0200, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    cur_tag = "saturate_hazard";
    for (int i = 0; i < 5; i++) train(32'h8000_0040, 0);
    go(32'h8000_0040);
    step(0, 1, 1, 32'h8000_0500, 1, 0, 0, 1, 32'h8000_0040, 1);
    step(0, 1, 1, 32'h8000_0500, 1, 0, 0, 1, 32'h8000_0040, 1);
    step(0, 0, 1, 32'h8000_0500, 1, 0, 0, 0, 0, 0);
    idle(1);

    cur_tag = "wrap";
    go(32'hFFFF_FFFC);
    idle(2);

    cur_tag = "midop_reset";
    step(1, 1, 1, 32'h1234_5678, 0, 1, 32'h8000_0900, 1, 32'h8000_0040, 1);
    go(32'h8000_0020);
    step(0, 0, 1, 32'h8000_0700, 1, 0, 0, 0, 0, 0);
    idle(1);

    cur_tag = "random";
    for (int n = 0; n < 3000; n++) begin
      bit          r, st, sel, fv, red, tv, tk;
      logic [31:0] jmp, rpc, tpc;
      r   = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 4) == 0);
      sel = ($urandom_range(0, 2) == 0);
      fv  = ($urandom_range(0, 3) != 0);
      red = ($urandom_range(0, 9) == 0);
      rpc = 32'h8000_0000 | (32'($urandom_range(0, 127)) << 2);
      if ($urandom_range(0, 19) == 0) rpc = $urandom;
      jmp = m_pc + (32'($urandom_range(0, 63)) << 2) - 32'd128;
      if ($urandom_range(0, 9) == 0) jmp = $urandom;
      tv  = ($urandom_range(0, 9) < 4);
      tk  = $urandom_range(0, 1) == 1;
      tpc = ($urandom_range(0, 1) == 0) ? m_pc : (32'h8000_0000 | (32'($urandom_range(0, 63)) << 2));
      step(r, st, sel, jmp, fv, red, rpc, tv, tpc, tk);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending expectations", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
